fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline, directly upstream of ID. It owns the PC register and drives the synchronous instruction SRAM. It applies branch/jump redirects from `br_bus` and produces `if_to_id_bus` (`{ce, pc}`). It also captures the instruction SRAM read data while ID is stalled, so ID always sees the instruction that matches its latched PC.

## Interface
Parameters:
- `RESET_PC`, default 32'hBFBF_FFFC: PC register reset value. The first fetched address is `RESET_PC + 4` = 32'hBFC0_0000.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `stall`  in  `StallBus` (6)  stall vector; bit0 = PC/IF, bit1 = IF→ID register; `Stop`/`NoStop` encoding.
- `br_bus`  in  `BR_WD` (33)  `{br_e, br_addr[31:0]}` from ID.
- `if_to_id_bus`  out  `IF_TO_ID_WD` (33)  `{ce, pc[31:0]}`.
- `inst_sram_en`  out  1  SRAM read enable.
- `inst_sram_wen`  out  4  always 4'b0000.
- `inst_sram_addr`  out  32  fetch address.
- `inst_sram_wdata`  out  32  always 32'b0.
- `inst_sram_rdata`  in  32  SRAM data; valid one cycle after the address.
- `fetch_inst`  out  32  instruction presented to ID's decoder.

## Operation
- State registers:
  - `pc_r`, reset `RESET_PC`.
  - `ce_r`, reset 0.
  - `hold_r`, reset 0.
  - FSM state, reset `RESET`.
- Next-PC selection: `br_e ? br_addr : pc_r + 32'd4`. The add wraps modulo 2^32 with no carry out.
- Each clock with `stall[0]==NoStop`: `pc_r <= next_pc`, `ce_r <= 1`.
- Each clock with `stall[0]==Stop`: `pc_r` and `ce_r` hold, and `br_bus` is ignored. ID keeps `br_bus` stable while it is stalled, so the redirect is taken on the first unstalled cycle.
- SRAM outputs: `inst_sram_en = ce_r`, `inst_sram_addr = pc_r`. `if_to_id_bus = {ce_r, pc_r}`.
- FSM states:
  - `RESET`: `ce_r = 0`, `fetch_inst = 0`. Goes to `RUN` on the first clock after reset release.
  - `RUN`: `fetch_inst = inst_sram_rdata`.
    - If `stall[1]==Stop` at a clock edge: `hold_r <= inst_sram_rdata` and go to `HOLD`.
  - `HOLD`: `fetch_inst = hold_r`.
    - If `stall[1]==NoStop` at a clock edge: go to `RUN`.
    - While stalled: stay in `HOLD`; `hold_r` is not overwritten.
- After a stall releases: `pc_r` was frozen throughout, so the `inst_sram_rdata` seen in the first `RUN` cycle matches the PC now latched by ID.
- Simultaneous `br_e` and `stall[0]==Stop`: the stall wins; PC holds.
- `rst` asserted mid-operation: all state returns to reset values immediately (asynchronous); the FSM goes to `RESET`.

## Timing
- Redirect latency: `br_e` sampled at edge N gives `inst_sram_addr = br_addr` in cycle N+1. The instruction in the delay slot (already fetched) is not cancelled.
- Instruction latency: address in cycle N, data on `fetch_inst` in cycle N+1.
- Hold capture takes 1 cycle. Release is 0-cycle: `fetch_inst` returns to the SRAM path in the cycle after the edge where `stall[1]==NoStop`.
- Reset outputs: `inst_sram_en = 0`, `inst_sram_addr = RESET_PC`, `if_to_id_bus = {1'b0, RESET_PC}`, `fetch_inst = 0`.

## Configuration
- `FETCH_INST_HOLD_EN`
  - Defined: `hold_r` and the `HOLD` state are built as described.
  - Undefined: `fetch_inst = inst_sram_rdata` in every cycle after `RESET`, and the FSM has only `RESET` and `RUN`. ID must then provide its own instruction buffering.

## Structure
- `StallBus`, `BR_WD`, `IF_TO_ID_WD`, `Stop`/`NoStop` and the FSM state encoding live in the shared defines header.
- One sub-module: `inst_hold_buf`. It contains the FSM and `hold_r`, with inputs `stall[1]` and `inst_sram_rdata` and output `fetch_inst`. It is instantiated only under `FETCH_INST_HOLD_EN`.

## Test plan
- Reset release, no stalls, no branches -> `inst_sram_addr` reads 32'hBFC0_0000, then …0004, …0008; `ce` rises on the first edge after reset.
- `br_bus = {1, 32'hBFC0_0100}` for one cycle while fetching 32'hBFC0_0008 -> next address is 32'hBFC0_0100, then …0104.
- `stall[1:0] = 2'b11` for 3 cycles while rdata for PC 32'hBFC0_000C is 32'h2408_0001 and the SRAM keeps changing -> `fetch_inst` stays 32'h2408_0001; on release, PC resumes at 32'hBFC0_0010.
- `stall[0] = Stop` concurrent with `br_e = 1` to 32'h8000_0000 -> PC holds; on the first unstalled edge PC = 32'h8000_0000.
- `pc_r = 32'hFFFF_FFFC`, no branch -> wraps to 32'h0000_0000.
- `rst` asserted mid-stall in `HOLD` -> outputs return to reset values asynchronously; after release, fetch restarts at 32'hBFC0_0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage: bus widths, the
// stall-vector encoding and the fetch FSM state type.
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

  // Stall vector: bit0 freezes PC/IF, bit1 freezes the IF->ID register.
  localparam int StallBus    = 6;
  // {br_e, br_addr[31:0]}
  localparam int BR_WD       = 33;
  // {ce, pc[31:0]}
  localparam int IF_TO_ID_WD = 33;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_inst_hold_buf.sv
// ----------------------------------------------------------------------------
// inst_hold_buf
// Keeps the instruction seen by ID stable while the IF->ID register is
// stalled. The SRAM output keeps moving during a stall, so the word present
// on the stalling edge is captured and replayed until the stall releases.
//
// Ports:
//   clk           in   pipeline clock, rising edge
//   rst           in   asynchronous active-high reset
//   i_stall       in   stall[1] (IF->ID register stall, Stop = 1)
//   i_rdata       in   instruction SRAM read data
//   o_fetch_inst  out  instruction presented to the ID decoder
// ----------------------------------------------------------------------------
module inst_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_fetch_inst
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_hold;
  logic         w_capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RESET;
      r_hold  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_hold <= i_rdata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    o_fetch_inst = i_rdata;
    case (r_state)
      ST_RESET: begin
        o_fetch_inst = 32'd0;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_stall == Stop) begin
          w_capture    = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Release is immediate: the frozen PC means the SRAM word in the
        // first RUN cycle already matches ID's PC.
        o_fetch_inst = r_hold;
        if (i_stall == NoStop) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        o_fetch_inst = 32'd0;
        w_state_next = ST_RESET;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives
// the synchronous instruction SRAM, applies branch/jump redirects and hands
// {ce, pc} plus the fetched instruction to ID.
//
// Build option: FETCH_INST_HOLD_EN
//   defined   - inst_hold_buf replays the instruction while stall[1] is held.
//   undefined - fetch_inst follows the SRAM directly after reset; ID must
//               buffer the instruction itself.
//
// Ports:
//   clk              in   pipeline clock, rising edge
//   rst              in   asynchronous active-high reset
//   stall            in   stall vector (bit0 PC/IF, bit1 IF->ID)
//   br_bus           in   {br_e, br_addr}
//   if_to_id_bus     out  {ce, pc}
//   inst_sram_en     out  SRAM read enable
//   inst_sram_wen    out  SRAM byte write enables (always 0)
//   inst_sram_addr   out  fetch address
//   inst_sram_wdata  out  SRAM write data (always 0)
//   inst_sram_rdata  in   SRAM read data, one cycle after the address
//   fetch_inst       out  instruction presented to ID's decoder
// ----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [StallBus-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [31:0]            fetch_inst
);

  logic [31:0] r_pc;
  logic        r_ce;
  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_next_pc;

  assign w_br_e    = br_bus[32];
  assign w_br_addr = br_bus[31:0];
  // 32-bit add wraps naturally at 2^32.
  assign w_next_pc = w_br_e ? w_br_addr : (r_pc + 32'd4);

  // A PC stall also masks br_bus; ID holds it stable so the redirect is
  // taken on the first unstalled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_ce <= 1'b0;
    end else if (stall[0] == NoStop) begin
      r_pc <= w_next_pc;
      r_ce <= 1'b1;
    end
  end

  assign inst_sram_en    = r_ce;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wdata = 32'd0;
  assign if_to_id_bus    = {r_ce, r_pc};

`ifdef FETCH_INST_HOLD_EN
  // Stall bits above the IF->ID register belong to later stages.
  logic w_stall_unused;
  assign w_stall_unused = ^stall[StallBus-1:2];

  inst_hold_buf u_inst_hold_buf (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (stall[1]),
    .i_rdata      (inst_sram_rdata),
    .o_fetch_inst (fetch_inst)
  );
`else
  // Without the hold buffer the IF->ID stall does not affect this stage.
  logic w_stall_unused;
  assign w_stall_unused = ^stall[StallBus-1:1];

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    fetch_inst   = inst_sram_rdata;
    case (r_state)
      ST_RESET: begin
        fetch_inst   = 32'd0;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      default: begin
        fetch_inst   = 32'd0;
        w_state_next = ST_RESET;
      end
    endcase
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural SRAM feeds the DUT; a
// reference model of PC/ce/FSM queues the expected fetch_inst for each edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
`ifdef FETCH_INST_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] fetch_inst;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .fetch_inst      (fetch_inst)
  );

  // SRAM contents; scr perturbs the read data to model a changing SRAM.
  logic [31:0] scr;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'hBFC0_000C) ? 32'h2408_0001 : (a ^ 32'h1357_9BDF);
  endfunction

  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr) ^ scr;
  end

  // Reference model
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc, m_rdata, m_hold, exp_f;
  logic        m_ce;
  int          m_state;   // 0 RESET, 1 RUN, 2 HOLD
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_pc = RESET_PC; m_ce = 1'b0; m_state = 0; m_hold = 32'd0;
    exp_q.delete();
  endtask

  // Advance model by one edge, queue expected fetch_inst, then clock.
  task automatic tick();
    logic [31:0] rd_next, f_next;
    int st_next;
    rd_next = m_ce ? (mem(m_pc) ^ scr) : m_rdata;
    st_next = m_state;
    case (m_state)
      0: st_next = 1;
      1: if (HOLD_EN && stall[1]) begin st_next = 2; m_hold = m_rdata; end
      default: if (!stall[1]) st_next = 1;
    endcase
    f_next = (st_next == 0) ? 32'd0 : (st_next == 2) ? m_hold : rd_next;
    exp_q.push_back(f_next);
    if (!stall[0]) begin
      m_pc = br_bus[32] ? br_bus[31:0] : m_pc + 32'd4;
      m_ce = 1'b1;
    end
    m_rdata = rd_next;
    m_state = st_next;
    @(posedge clk); #1;
    $display("t=%0t addr=%h en=%b fetch=%h stall=%b br=%h", $time, inst_sram_addr,
             inst_sram_en, fetch_inst, stall[1:0], br_bus);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 6'd0; br_bus = 33'd0; scr = 32'd0;
    inst_sram_rdata = 32'd0; m_rdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=0", inst_sram_en); end
    n_checks++; if (inst_sram_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", inst_sram_addr, RESET_PC); end
    n_checks++; if (if_to_id_bus !== {1'b0, RESET_PC}) begin n_fail++; $display("FAIL reset_bus got=%h", if_to_id_bus); end
    n_checks++; if (fetch_inst !== 32'd0) begin n_fail++; $display("FAIL reset_fetch got=%h exp=0", fetch_inst); end
    n_checks++; if (inst_sram_wen !== 4'd0 || inst_sram_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wr wen=%h wdata=%h", inst_sram_wen, inst_sram_wdata); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_f = exp_q.pop_front();
      n_checks++; if (inst_sram_addr !== 32'hBFC0_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, inst_sram_addr, 32'hBFC0_0000 + 32'(4 * i)); end
      n_checks++; if (if_to_id_bus !== {1'b1, m_pc}) begin n_fail++; $display("FAIL seq_bus[%0d] got=%h exp=%h", i, if_to_id_bus, {1'b1, m_pc}); end
      n_checks++; if (fetch_inst !== exp_f) begin n_fail++; $display("FAIL seq_fetch[%0d] got=%h exp=%h", i, fetch_inst, exp_f); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] want [2];
    want[0] = 32'hBFC0_0100; want[1] = 32'hBFC0_0104;
    br_bus = {1'b1, 32'hBFC0_0100};
    for (int i = 0; i < 2; i++) begin
      tick();
      br_bus = 33'd0;
      exp_f = exp_q.pop_front();
      n_checks++; if (inst_sram_addr !== want[i]) begin n_fail++; $display("FAIL br_addr[%0d] got=%h exp=%h", i, inst_sram_addr, want[i]); end
      n_checks++; if (fetch_inst !== exp_f) begin n_fail++; $display("FAIL br_fetch[%0d] got=%h exp=%h", i, fetch_inst, exp_f); end
    end
  endtask

  task automatic test_hold();
    br_bus = {1'b1, 32'hBFC0_000C};
    tick(); br_bus = 33'd0; void'(exp_q.pop_front());
    tick(); exp_f = exp_q.pop_front();
    n_checks++; if (fetch_inst !== 32'h2408_0001) begin n_fail++; $display("FAIL hold_pre got=%h exp=24080001", fetch_inst); end
    stall = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      scr = $urandom | 32'h1;
      tick();
      exp_f = exp_q.pop_front();
      n_checks++; if (inst_sram_addr !== 32'hBFC0_0010) begin n_fail++; $display("FAIL hold_addr[%0d] got=%h exp=bfc00010", i, inst_sram_addr); end
      n_checks++; if (fetch_inst !== exp_f) begin n_fail++; $display("FAIL hold_fetch[%0d] got=%h exp=%h", i, fetch_inst, exp_f); end
      if (HOLD_EN) begin
        n_checks++; if (fetch_inst !== 32'h2408_0001) begin n_fail++; $display("FAIL hold_const[%0d] got=%h exp=24080001", i, fetch_inst); end
      end
    end
    stall = 6'd0; scr = 32'd0;
    tick(); exp_f = exp_q.pop_front();
    n_checks++; if (fetch_inst !== mem(32'hBFC0_0010)) begin n_fail++; $display("FAIL hold_release got=%h exp=%h", fetch_inst, mem(32'hBFC0_0010)); end
    n_checks++; if (inst_sram_addr !== 32'hBFC0_0014) begin n_fail++; $display("FAIL hold_resume got=%h exp=bfc00014", inst_sram_addr); end
  endtask

  task automatic test_stall_branch();
    stall = 6'b000001; br_bus = {1'b1, 32'h8000_0000};
    for (int i = 0; i < 2; i++) begin
      tick(); exp_f = exp_q.pop_front();
      n_checks++; if (inst_sram_addr !== 32'hBFC0_0014) begin n_fail++; $display("FAIL sb_hold[%0d] got=%h exp=bfc00014", i, inst_sram_addr); end
      n_checks++; if (fetch_inst !== exp_f) begin n_fail++; $display("FAIL sb_fetch[%0d] got=%h exp=%h", i, fetch_inst, exp_f); end
    end
    stall = 6'd0;
    tick(); br_bus = 33'd0; exp_f = exp_q.pop_front();
    n_checks++; if (inst_sram_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL sb_take got=%h exp=80000000", inst_sram_addr); end
    n_checks++; if (fetch_inst !== exp_f) begin n_fail++; $display("FAIL sb_take_fetch got=%h exp=%h", fetch_inst, exp_f); end
  endtask

  task automatic test_wrap();
    br_bus = {1'b1, 32'hFFFF_FFFC};
    tick(); br_bus = 33'd0; void'(exp_q.pop_front());
    n_checks++; if (inst_sram_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre got=%h exp=fffffffc", inst_sram_addr); end
    tick(); exp_f = exp_q.pop_front();
    n_checks++; if (inst_sram_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap got=%h exp=00000000", inst_sram_addr); end
    n_checks++; if (fetch_inst !== exp_f) begin n_fail++; $display("FAIL wrap_fetch got=%h exp=%h", fetch_inst, exp_f); end
  endtask

  task automatic test_reset_mid_hold();
    stall = 6'b000011;
    tick(); void'(exp_q.pop_front());
    tick(); void'(exp_q.pop_front());
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL mrst_en got=%b exp=0", inst_sram_en); end
    n_checks++; if (inst_sram_addr !== RESET_PC) begin n_fail++; $display("FAIL mrst_addr got=%h exp=%h", inst_sram_addr, RESET_PC); end
    n_checks++; if (fetch_inst !== 32'd0) begin n_fail++; $display("FAIL mrst_fetch got=%h exp=0", fetch_inst); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; stall = 6'd0;
    tick(); exp_f = exp_q.pop_front();
    n_checks++; if (inst_sram_addr !== 32'hBFC0_0000 || inst_sram_en !== 1'b1) begin n_fail++; $display("FAIL mrst_restart addr=%h en=%b exp=bfc00000/1", inst_sram_addr, inst_sram_en); end
    n_checks++; if (fetch_inst !== exp_f) begin n_fail++; $display("FAIL mrst_fetch0 got=%h exp=%h", fetch_inst, exp_f); end
    tick(); exp_f = exp_q.pop_front();
    n_checks++; if (fetch_inst !== mem(32'hBFC0_0000)) begin n_fail++; $display("FAIL mrst_fetch1 got=%h exp=%h", fetch_inst, mem(32'hBFC0_0000)); end
    n_checks++; if (inst_sram_addr !== 32'hBFC0_0004) begin n_fail++; $display("FAIL mrst_addr1 got=%h exp=bfc00004", inst_sram_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_hold();
    test_stall_branch();
    test_wrap();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
